btn_event_capture: RTL and testbench



---
 rtl/btn_pkg.sv | 26 ++
 rtl/btn_hold_timer.sv | 31 +++
 rtl/btn_event_capture.sv | 108 ++++++++++
 tb/tb_btn_event_capture.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for the debounced-button event path: FSM states,
// event bit positions and the ms/ns -> clock-cycle conversion.
package btn_pkg;

   typedef enum logic [1:0] {
      WAIT_REL = 2'd0,
      IDLE     = 2'd1,
      PRESSED  = 2'd2,
      LONG     = 2'd3
   } BtnEvtState_e;

   localparam int EVT_PRESS   = 0;
   localparam int EVT_RELEASE = 1;
   localparam int EVT_LONG    = 2;
   localparam int NUM_EVT     = 3;

   // Number of clock cycles in a time span of 'ms' milliseconds for a
   // clock of period 'ns' nanoseconds. Done in 64 bits so long hold times
   // at fast clocks do not overflow the intermediate product.
   function automatic int ms_to_cycles(input int ms, input int ns);
      longint prod;
      prod = (longint'(1000000) * longint'(ms)) / longint'(ns);
      return int'(prod);
   endfunction

endpackage

// File: rtl/btn_hold_timer.sv
// Hold-duration timer for a pressed button. Restarts from zero on clear,
// counts while enabled and flags the last cycle of the hold window.
module btn_hold_timer #(
   parameter int HOLD_CYCLE = 10
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic done
);

   localparam int CW = $clog2(HOLD_CYCLE + 1);
   localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLE - 1);

   logic [CW-1:0] count;

   // Count enabled cycles; parks at LAST so it can never run past the window.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != LAST)) begin
         count <= count + 1'b1;
      end
   end

   assign done = enable && (count == LAST);

endmodule

// File: rtl/btn_event_capture.sv
// Turns the debounced button level into sticky press / release / long-press
// events, a saturating press counter and a maskable interrupt for the bus.
module btn_event_capture
   import btn_pkg::*;
#(
   parameter int HOLD_TIME_MS  = 1000,
   parameter int CLK_PERIOD_NS = 20,
   parameter int CNT_W         = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_btn,
   input  logic [2:0]       i_clr,
   input  logic             i_clr_cnt,
   input  logic [2:0]       i_irq_en,
   output logic [2:0]       o_evt_pend,
   output logic [CNT_W-1:0] o_press_cnt,
   output logic [1:0]       o_state,
   output logic             o_irq
);

   localparam int HOLD_CYCLE = ms_to_cycles(HOLD_TIME_MS, CLK_PERIOD_NS);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   BtnEvtState_e         state, state_nxt;
   logic [NUM_EVT-1:0]   evt_set;
   logic                 press;
   logic                 hold_clr, hold_en, hold_done;

   // Timer control is decoded straight from state/input so the timer's
   // done flag does not loop back through the next-state logic.
   assign hold_clr = (state == IDLE) && i_btn;
   assign hold_en  = (state == PRESSED) && i_btn;

   btn_hold_timer #(
      .HOLD_CYCLE (HOLD_CYCLE)
   ) u_hold (
      .clk    (i_clk),
      .rst_n  (i_rst_n),
      .clear  (hold_clr),
      .enable (hold_en),
      .done   (hold_done)
   );

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= WAIT_REL;
      else          state <= state_nxt;
   end

   // Next state and event generation; release is tested before the hold
   // timer so a release on the final hold edge never yields a long event.
   always_comb begin
      state_nxt = state;
      evt_set   = '0;
      press     = 1'b0;
      case (state)
         WAIT_REL: begin
            if (!i_btn) state_nxt = IDLE;
         end
         IDLE: begin
            if (i_btn) begin
               state_nxt          = PRESSED;
               evt_set[EVT_PRESS] = 1'b1;
               press              = 1'b1;
            end
         end
         PRESSED: begin
            if (!i_btn) begin
               state_nxt            = IDLE;
               evt_set[EVT_RELEASE] = 1'b1;
            end else if (hold_done) begin
               state_nxt         = LONG;
               evt_set[EVT_LONG] = 1'b1;
            end
         end
         LONG: begin
            if (!i_btn) begin
               state_nxt            = IDLE;
               evt_set[EVT_RELEASE] = 1'b1;
            end
         end
         default: state_nxt = WAIT_REL;
      endcase
   end

   // Sticky pending flags: a new event beats a same-edge clear.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) o_evt_pend <= '0;
      else          o_evt_pend <= (o_evt_pend & ~i_clr) | evt_set;
   end

   // Saturating press counter; a press coinciding with a clear counts as 1.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_press_cnt <= '0;
      end else if (press) begin
         if (i_clr_cnt)                  o_press_cnt <= CNT_W'(1);
         else if (o_press_cnt != CNT_MAX) o_press_cnt <= o_press_cnt + 1'b1;
      end else if (i_clr_cnt) begin
         o_press_cnt <= '0;
      end
   end

   assign o_state = state;
   assign o_irq   = |(o_evt_pend & i_irq_en);

endmodule

// File: tb/tb_btn_event_capture.sv
// Directed bench for btn_event_capture. Stimulus pushes hand-derived
// expected outputs tagged with the cycle they apply to; a monitor on the
// falling edge pops and compares them.
module tb_btn_event_capture;

   logic       i_clk = 1'b0;
   logic       i_rst_n = 1'b0;
   logic       i_btn = 1'b1;
   logic [2:0] i_clr = 3'b000;
   logic       i_clr_cnt = 1'b0;
   logic [2:0] i_irq_en = 3'b111;
   logic [2:0] o_evt_pend;
   logic [7:0] o_press_cnt;
   logic [1:0] o_state;
   logic       o_irq;

   btn_event_capture #(
      .HOLD_TIME_MS  (1),
      .CLK_PERIOD_NS (100000),
      .CNT_W         (8)
   ) dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_btn       (i_btn),
      .i_clr       (i_clr),
      .i_clr_cnt   (i_clr_cnt),
      .i_irq_en    (i_irq_en),
      .o_evt_pend  (o_evt_pend),
      .o_press_cnt (o_press_cnt),
      .o_state     (o_state),
      .o_irq       (o_irq)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      int         cyc;
      string      name;
      logic [2:0] pend;
      logic [7:0] cnt;
      logic [1:0] st;
      logic       irq;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   localparam logic [1:0] S_WAIT = 2'd0, S_IDLE = 2'd1, S_PRESS = 2'd2, S_LONG = 2'd3;

   always @(posedge i_clk) cyc <= cyc + 1;

   // Monitor: compare every expectation due by the current cycle.
   always @(negedge i_clk) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         exp_t e;
         e = q.pop_front();
         checks++;
         if (o_evt_pend !== e.pend || o_press_cnt !== e.cnt ||
             o_state !== e.st || o_irq !== e.irq) begin
            errors++;
            $display("FAIL %s: got pend=%b cnt=%0d st=%0d irq=%b, want pend=%b cnt=%0d st=%0d irq=%b",
                     e.name, o_evt_pend, o_press_cnt, o_state, o_irq,
                     e.pend, e.cnt, e.st, e.irq);
         end
      end
   end

   task automatic exp_push(input string n, input logic [2:0] p, input int c,
                           input logic [1:0] s);
      exp_t e;
      e.cyc  = cyc;
      e.name = n;
      e.pend = p;
      e.cnt  = 8'(c);
      e.st   = s;
      e.irq  = |(p & i_irq_en);
      q.push_back(e);
   endtask

   // Drive inputs for one clock edge; clear pulses last a single edge.
   task automatic step(input logic btn, input logic [2:0] clr, input logic cc);
      i_btn     = btn;
      i_clr     = clr;
      i_clr_cnt = cc;
      @(posedge i_clk);
      #1;
      i_clr     = 3'b000;
      i_clr_cnt = 1'b0;
   endtask

   initial begin
      // 1: button held through reset produces nothing.
      repeat (2) @(posedge i_clk);
      #1;
      exp_push("reset", 3'b000, 0, S_WAIT);
      i_rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 3'b000, 1'b0);
         if (i == 0 || i == 19) exp_push("held_thru_reset", 3'b000, 0, S_WAIT);
      end
      step(1'b0, 3'b000, 1'b0);
      exp_push("arm_idle", 3'b000, 0, S_IDLE);

      // 2: short press.
      step(1'b1, 3'b000, 1'b0);
      exp_push("short_press", 3'b001, 1, S_PRESS);
      for (int i = 0; i < 3; i++) step(1'b1, 3'b000, 1'b0);
      exp_push("short_hold", 3'b001, 1, S_PRESS);
      step(1'b0, 3'b000, 1'b0);
      exp_push("short_release", 3'b011, 1, S_IDLE);
      step(1'b0, 3'b111, 1'b0);
      exp_push("clear_all_1", 3'b000, 1, S_IDLE);

      // 3: long press, 15 cycles.
      step(1'b1, 3'b000, 1'b0);
      exp_push("long_press", 3'b001, 2, S_PRESS);
      for (int i = 1; i <= 9; i++) step(1'b1, 3'b000, 1'b0);
      exp_push("long_edge9", 3'b001, 2, S_PRESS);
      step(1'b1, 3'b000, 1'b0);
      exp_push("long_edge10", 3'b101, 2, S_LONG);
      for (int i = 0; i < 4; i++) step(1'b1, 3'b000, 1'b0);
      exp_push("long_held", 3'b101, 2, S_LONG);
      step(1'b0, 3'b000, 1'b0);
      exp_push("long_release", 3'b111, 2, S_IDLE);
      step(1'b0, 3'b111, 1'b0);
      exp_push("clear_all_2", 3'b000, 2, S_IDLE);

      // 4: release on exactly the 10th hold edge.
      step(1'b1, 3'b000, 1'b0);
      exp_push("edge_press", 3'b001, 3, S_PRESS);
      for (int i = 1; i <= 9; i++) step(1'b1, 3'b000, 1'b0);
      step(1'b0, 3'b000, 1'b0);
      exp_push("edge_release", 3'b011, 3, S_IDLE);

      // 5: set beats clear; clear all on an idle cycle.
      step(1'b1, 3'b001, 1'b0);
      exp_push("set_beats_clr", 3'b011, 4, S_PRESS);
      step(1'b0, 3'b000, 1'b0);
      exp_push("set_beats_rel", 3'b011, 4, S_IDLE);
      step(1'b0, 3'b111, 1'b0);
      exp_push("clear_all_3", 3'b000, 4, S_IDLE);
      step(1'b0, 3'b001, 1'b0);
      exp_push("clear_clear", 3'b000, 4, S_IDLE);

      // 6: saturation, clear-with-press, masked interrupt.
      i_irq_en = 3'b100;
      for (int i = 0; i < 300; i++) begin
         step(1'b1, 3'b000, 1'b0);
         exp_push("sat_press", (i == 0) ? 3'b001 : 3'b011,
                  (5 + i > 255) ? 255 : 5 + i, S_PRESS);
         step(1'b0, 3'b000, 1'b0);
         exp_push("sat_release", 3'b011, (5 + i > 255) ? 255 : 5 + i, S_IDLE);
      end
      step(1'b1, 3'b000, 1'b1);
      exp_push("clrcnt_press", 3'b011, 1, S_PRESS);
      for (int i = 1; i <= 9; i++) step(1'b1, 3'b000, 1'b0);
      exp_push("irq_masked", 3'b011, 1, S_PRESS);
      step(1'b1, 3'b000, 1'b0);
      exp_push("irq_long", 3'b111, 1, S_LONG);
      step(1'b0, 3'b000, 1'b0);
      exp_push("irq_long_rel", 3'b111, 1, S_IDLE);
      step(1'b0, 3'b100, 1'b0);
      exp_push("irq_cleared", 3'b011, 1, S_IDLE);
      step(1'b0, 3'b000, 1'b1);
      exp_push("clrcnt_only", 3'b011, 0, S_IDLE);

      // Reset in the middle of a press, then re-arm.
      step(1'b1, 3'b000, 1'b0);
      exp_push("pre_rst_press", 3'b011, 1, S_PRESS);
      step(1'b1, 3'b000, 1'b0);
      i_rst_n = 1'b0;
      exp_push("mid_reset", 3'b000, 0, S_WAIT);
      step(1'b1, 3'b000, 1'b0);
      exp_push("in_reset", 3'b000, 0, S_WAIT);
      i_rst_n = 1'b1;
      step(1'b1, 3'b000, 1'b0);
      exp_push("rearm_wait", 3'b000, 0, S_WAIT);
      step(1'b0, 3'b000, 1'b0);
      exp_push("rearm_idle", 3'b000, 0, S_IDLE);
      step(1'b1, 3'b000, 1'b0);
      exp_push("rearm_press", 3'b001, 1, S_PRESS);

      repeat (3) @(negedge i_clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, want 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
